exu_oitf: RTL
=============

# exu_oitf

Outstanding Instruction Track FIFO for the EXU long-pipe path. Dispatch allocates one entry per long-pipe instruction (load/store issued to the LSU), recording its destination register and PC. The long-pipe writeback stage retires entries strictly in order, reading the head entry's `rdwen`/`rdidx` to steer the register-file write. Dispatch also gets combinational RAW/WAW hazard flags against all in-flight entries so it can stall dependent instructions.

## Interface
- `OITF_DEPTH`, 2, number of entries; legal range 2..16; need not be a power of two.
- `OITF_PTR_W`, 1, pointer width; must equal ceil(log2(`OITF_DEPTH`)).
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `dis_ready`  out  1  a free entry exists (`~full`).
- `dis_ena`  in  1  allocate an entry this cycle; only legal while `dis_ready`=1.
- `disp_i_rdwen`  in  1  dispatched instruction writes rd.
- `disp_i_rdidx`  in  `RFIDX_WIDTH`  dispatched rd index.
- `disp_i_pc`  in  `PC_SIZE`  dispatched instruction PC.
- `disp_i_rs1en`, `disp_i_rs2en`  in  1 each  source operand used.
- `disp_i_rs1idx`, `disp_i_rs2idx`  in  `RFIDX_WIDTH` each  source indices.
- `oitfrd_match_disprs1`, `oitfrd_match_disprs2`, `oitfrd_match_disprd`  out  1 each  hazard flags.
- `dis_ptr`  out  `OITF_PTR_W`  index the next allocation will use.
- `ret_ena`  in  1  retire the head entry this cycle (from long-pipe writeback).
- `ret_rdwen`  out  1  head entry writes rd.
- `ret_rdidx`  out  `RFIDX_WIDTH`  head entry rd index.
- `ret_pc`  out  `PC_SIZE`  head entry PC (for long-pipe exception reporting).
- `ret_ptr`  out  `OITF_PTR_W`  head index.
- `oitf_empty`  out  1  no entries in flight.

## Operation
- Storage: per entry, `vld`, `rdwen`, `rdidx`, and `pc` registers. Two pointers, `alc_ptr` and `ret_ptr`, each paired with a wrap flag bit.
- Allocate on `dis_ena`:
  - write the entry at `alc_ptr`, set its `vld`;
  - increment `alc_ptr`; on reaching `OITF_DEPTH-1` it wraps to 0 and toggles the wrap flag.
- Retire on `ret_ena & ~oitf_empty`:
  - clear `vld` at `ret_ptr`;
  - increment `ret_ptr` with the same wrap rule.
- `ret_ena` while empty is ignored: no state change.
- `dis_ena` while full is ignored: no write, no pointer move. The bench flags it as a protocol error.
- Status decode:
  - `oitf_empty` = (pointers equal) & (flags equal).
  - full = (pointers equal) & (flags differ).
  - `dis_ready` = ~full.
- Allocate and retire in the same cycle are both performed. Occupancy is unchanged, and the same slot may be freed and reused only via different pointers, never the same slot unless the FIFO is full-then-retire (allocation is blocked in that case).
- Retire outputs:
  - `ret_rdwen`, `ret_rdidx`, and `ret_pc` are the head entry's fields, combinational from registers.
  - These outputs are don't-care when empty, but are driven as 0 when `oitf_empty`.
- Hazard match, combinational, OR over all entries with `vld`=1 and `rdwen`=1:
  - `oitfrd_match_disprs1` = `disp_i_rs1en` & (`rdidx`==`disp_i_rs1idx`);
  - `oitfrd_match_disprs2` likewise with rs2;
  - `oitfrd_match_disprd` = `disp_i_rdwen` & (`rdidx`==`disp_i_rdidx`).
  - Index 0 is not special-cased.
- An entry being retired in the current cycle still participates in matching that cycle.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - pointers, flags, and all `vld` bits become 0;
  - `oitf_empty`=1, `dis_ready`=1, all match flags 0, `ret_*` outputs 0, `dis_ptr`=0, `ret_ptr`=0.
- Reset mid-operation discards all in-flight entries in one cycle; `rdidx`/`pc` contents need not be cleared.
- Allocation latency is 1 cycle. An entry allocated at edge N is visible on `ret_*`, on match flags, and in `oitf_empty`/`dis_ready` after edge N.
- Retire latency is 1 cycle. The slot is free (`dis_ready` rises when previously full) after the retiring edge.
- `dis_ready` depends only on registered state, never on `ret_ena`, so there is no dispatch-to-retire combinational path.
- Outputs `ret_*` depend only on registers. `ret_ena` may therefore depend combinationally on `ret_rdwen` through the writeback stage without creating a loop.

## Test plan
- Reset, then idle → `oitf_empty`=1, `dis_ready`=1, `dis_ptr`=0, `ret_ptr`=0, all matches 0.
- `OITF_DEPTH`=2: allocate rd=5, pc=0x80000000, then allocate rd=7 → after 2nd edge full, `dis_ready`=0, `ret_rdidx`=5, `ret_pc`=0x80000000; `dis_ena` while full leaves state unchanged.
- From full, retire once → `ret_rdidx`=7, `dis_ready`=1. Then allocate rd=9 and retire simultaneously → `ret_rdidx`=9, pointers wrapped, flags consistent, occupancy 1.
- One entry in flight (rd=3, rdwen=1); present rs1idx=3 rs1en=1, rs2idx=3 rs2en=0, rdidx=3 rdwen=1 → rs1 match=1, rs2 match=0, rd match=1. An entry with rdwen=0 and rd=3 → all 0.
- `ret_ena` while empty → no pointer change, `oitf_empty` stays 1. Reset asserted with 2 entries in flight → empty next cycle.
- Random alloc/retire for 10k cycles against a queue model → `ret_*` order, `oitf_empty`/`dis_ready`, and match flags agree every cycle.

Source files
------------

// File: rtl/exu_oitf.sv
// exu_oitf: outstanding instruction track FIFO for the EXU long-pipe path.
// Dispatch allocates one entry per long-pipe instruction; writeback retires
// entries in order. Dispatch also receives RAW/WAW hazard flags against every
// in-flight entry that writes a destination register.
module exu_oitf #(
    parameter int OITF_DEPTH  = 2,
    parameter int OITF_PTR_W  = 1,
    parameter int RFIDX_WIDTH = 5,
    parameter int PC_SIZE     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,

    output logic                   dis_ready,
    input  logic                   dis_ena,
    input  logic                   disp_i_rdwen,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
    input  logic [PC_SIZE-1:0]     disp_i_pc,
    input  logic                   disp_i_rs1en,
    input  logic                   disp_i_rs2en,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,
    output logic                   oitfrd_match_disprs1,
    output logic                   oitfrd_match_disprs2,
    output logic                   oitfrd_match_disprd,
    output logic [OITF_PTR_W-1:0]  dis_ptr,

    input  logic                   ret_ena,
    output logic                   ret_rdwen,
    output logic [RFIDX_WIDTH-1:0] ret_rdidx,
    output logic [PC_SIZE-1:0]     ret_pc,
    output logic [OITF_PTR_W-1:0]  ret_ptr,
    output logic                   oitf_empty
);

    localparam logic [OITF_PTR_W-1:0] LAST_PTR = OITF_PTR_W'(OITF_DEPTH - 1);

    logic [OITF_DEPTH-1:0]  vld_q;
    logic [OITF_DEPTH-1:0]  rdwen_q;
    logic [RFIDX_WIDTH-1:0] rdidx_q [OITF_DEPTH];
    logic [PC_SIZE-1:0]     pc_q    [OITF_DEPTH];

    logic [OITF_PTR_W-1:0]  alc_ptr_q;
    logic [OITF_PTR_W-1:0]  ret_ptr_q;
    logic                   alc_flg_q;
    logic                   ret_flg_q;

    logic                   full;
    logic                   alc_fire;
    logic                   ret_fire;

    // Status comes only from registered pointers, so dis_ready never sees ret_ena.
    assign oitf_empty = (alc_ptr_q == ret_ptr_q) & (alc_flg_q == ret_flg_q);
    assign full       = (alc_ptr_q == ret_ptr_q) & (alc_flg_q != ret_flg_q);
    assign dis_ready  = ~full;

    // Requests that arrive while full (allocate) or empty (retire) are dropped.
    assign alc_fire = dis_ena & ~full;
    assign ret_fire = ret_ena & ~oitf_empty;

    assign dis_ptr = alc_ptr_q;
    assign ret_ptr = ret_ptr_q;

    // Control state: pointers, wrap flags and per-entry valid bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alc_ptr_q <= '0;
            ret_ptr_q <= '0;
            alc_flg_q <= 1'b0;
            ret_flg_q <= 1'b0;
            vld_q     <= '0;
        end else begin
            if (alc_fire) begin
                vld_q[alc_ptr_q] <= 1'b1;
                if (alc_ptr_q == LAST_PTR) begin
                    alc_ptr_q <= '0;
                    alc_flg_q <= ~alc_flg_q;
                end else begin
                    alc_ptr_q <= alc_ptr_q + 1'b1;
                end
            end
            // Allocate and retire never target the same slot: equal pointers
            // mean either empty (no retire) or full (no allocate).
            if (ret_fire) begin
                vld_q[ret_ptr_q] <= 1'b0;
                if (ret_ptr_q == LAST_PTR) begin
                    ret_ptr_q <= '0;
                    ret_flg_q <= ~ret_flg_q;
                end else begin
                    ret_ptr_q <= ret_ptr_q + 1'b1;
                end
            end
        end
    end

    // Entry payload: written on allocation, never reset (vld gates its use).
    always_ff @(posedge clk) begin
        if (alc_fire) begin
            rdwen_q[alc_ptr_q] <= disp_i_rdwen;
            rdidx_q[alc_ptr_q] <= disp_i_rdidx;
            pc_q[alc_ptr_q]    <= disp_i_pc;
        end
    end

    // Head entry fields, forced to zero while nothing is in flight.
    always_comb begin
        ret_rdwen = 1'b0;
        ret_rdidx = '0;
        ret_pc    = '0;
        if (!oitf_empty) begin
            ret_rdwen = rdwen_q[ret_ptr_q];
            ret_rdidx = rdidx_q[ret_ptr_q];
            ret_pc    = pc_q[ret_ptr_q];
        end
    end

    // Hazard flags: OR of index compares over valid entries that write rd.
    always_comb begin
        oitfrd_match_disprs1 = 1'b0;
        oitfrd_match_disprs2 = 1'b0;
        oitfrd_match_disprd  = 1'b0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            if (vld_q[i] && rdwen_q[i]) begin
                if (disp_i_rs1en && (rdidx_q[i] == disp_i_rs1idx)) oitfrd_match_disprs1 = 1'b1;
                if (disp_i_rs2en && (rdidx_q[i] == disp_i_rs2idx)) oitfrd_match_disprs2 = 1'b1;
                if (disp_i_rdwen && (rdidx_q[i] == disp_i_rdidx))  oitfrd_match_disprd  = 1'b1;
            end
        end
    end

endmodule
